// File: rtl/uart_rx_alu_interface_pkg.sv
// Shared types and constants for the UART-receiver to ALU bridge.
// One-hot FSM encoding, default widths and the ALU opcode map.
package uart_rx_alu_interface_pkg;

    localparam int NB_DATA_DEF = 8;
    localparam int NB_OP_DEF   = 6;

    typedef enum logic [5:0] {
        ST_WAIT_A  = 6'b000001,
        ST_WAIT_B  = 6'b000010,
        ST_WAIT_OP = 6'b000100,
        ST_EXEC    = 6'b001000,
        ST_SEND    = 6'b010000,
        ST_WAIT_TX = 6'b100000
    } state_e;

    localparam logic [5:0] OP_ADD = 6'h20;
    localparam logic [5:0] OP_SUB = 6'h22;
    localparam logic [5:0] OP_AND = 6'h24;
    localparam logic [5:0] OP_OR  = 6'h25;
    localparam logic [5:0] OP_XOR = 6'h26;
    localparam logic [5:0] OP_NOR = 6'h27;
    localparam logic [5:0] OP_SRA = 6'h03;
    localparam logic [5:0] OP_SRL = 6'h02;

endpackage

// File: rtl/uart_rx_alu_interface_edge_detect_rise.sv
// Rising-edge detector: o_rise is high in the cycle the input is first seen high,
// zero latency, one pulse per low-to-high transition however long the level lasts.
module edge_detect_rise (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_sig,
    output logic o_rise
);

    logic sig_q;
    logic sig_d;

    always_comb begin
        sig_d = i_sig;
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign o_rise = i_sig & ~sig_q;

endmodule

// File: rtl/uart_rx_alu_interface.sv
// Collects A, B, opcode bytes from the UART receiver, runs one ALU cycle and hands the result
// to the transmitter; o_tx_start 2 clocks after the opcode byte, bytes during EXEC/SEND/WAIT_TX are dropped.
module uart_rx_alu_interface
    import uart_rx_alu_interface_pkg::*;
#(
    parameter int NB_DATA        = NB_DATA_DEF,
    parameter int NB_OP          = NB_OP_DEF,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_rx_done,
    input  logic [NB_DATA-1:0] i_rx_data,
    output logic [NB_DATA-1:0] o_alu_a,
    output logic [NB_DATA-1:0] o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    input  logic               i_tx_done,
    output logic               o_frame_err,
    output logic               o_overrun
);

    localparam int NB_CNT = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(TIMEOUT_CYCLES - 1);

    state_e             state_q, state_d;
    logic [NB_DATA-1:0] alu_a_q, alu_a_d;
    logic [NB_DATA-1:0] alu_b_q, alu_b_d;
    logic [NB_OP-1:0]   alu_op_q, alu_op_d;
    logic [NB_DATA-1:0] tx_data_q, tx_data_d;
    logic [NB_CNT-1:0]  cnt_q, cnt_d;
    logic               overrun_q, overrun_d;

    logic rx_evt;
    logic tx_evt;
    logic in_frame;
    logic busy;
    logic timeout_hit;

    edge_detect_rise u_rx_edge (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_sig   (i_rx_done),
        .o_rise  (rx_evt)
    );

    edge_detect_rise u_tx_edge (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_sig   (i_tx_done),
        .o_rise  (tx_evt)
    );

    assign in_frame    = (state_q == ST_WAIT_B) || (state_q == ST_WAIT_OP);
    assign busy        = (state_q == ST_EXEC) || (state_q == ST_SEND) || (state_q == ST_WAIT_TX);
    // A byte landing on the last count keeps the frame alive.
    assign timeout_hit = in_frame && !rx_evt && (cnt_q == CNT_LAST);

    always_comb begin
        state_d   = state_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_op_d  = alu_op_q;
        tx_data_d = tx_data_q;
        overrun_d = overrun_q;
        cnt_d     = '0;

        if (in_frame && !rx_evt && !timeout_hit) begin
            cnt_d = cnt_q + NB_CNT'(1);
        end

        if (busy && rx_evt) begin
            overrun_d = 1'b1;
        end

        unique case (state_q)
            ST_WAIT_A: begin
                if (rx_evt) begin
                    alu_a_d = i_rx_data;
                    state_d = ST_WAIT_B;
                end
            end
            ST_WAIT_B: begin
                if (rx_evt) begin
                    alu_b_d = i_rx_data;
                    state_d = ST_WAIT_OP;
                end else if (timeout_hit) begin
                    state_d = ST_WAIT_A;
                end
            end
            ST_WAIT_OP: begin
                if (rx_evt) begin
                    alu_op_d = i_rx_data[NB_OP-1:0];
                    state_d  = ST_EXEC;
                end else if (timeout_hit) begin
                    state_d = ST_WAIT_A;
                end
            end
            ST_EXEC: begin
                tx_data_d = i_alu_result;
                state_d   = ST_SEND;
            end
            ST_SEND: begin
                state_d = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                if (tx_evt) begin
                    state_d = ST_WAIT_A;
                end
            end
            default: begin
                state_d = ST_WAIT_A;
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= ST_WAIT_A;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_op_q  <= '0;
            tx_data_q <= '0;
            cnt_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_op_q  <= alu_op_d;
            tx_data_q <= tx_data_d;
            cnt_q     <= cnt_d;
            overrun_q <= overrun_d;
        end
    end

    // Decoded straight from the state flop so reset drops the pulse without a clock.
    assign o_tx_start  = (state_q == ST_SEND);
    assign o_frame_err = timeout_hit;
    assign o_alu_a     = alu_a_q;
    assign o_alu_b     = alu_b_q;
    assign o_alu_op    = alu_op_q;
    assign o_tx_data   = tx_data_q;
    assign o_overrun   = overrun_q;

endmodule
